// File: rtl/cpu_datapath.sv
// ==== cpu_datapath : 32-bit single-bus CPU datapath, one-hot bus/load strobes, 64-bit Z ====
// ==== rev 1.0 ====
`default_nettype none

module cpu_datapath (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Read,
  input  logic        IncPC,
  input  logic [4:0]  opcode,
  input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        HIin, LOin, Yin, Zhighin, Zlowin, PCin, IRin, MARin, MDRin, Inportin, Cin,
  input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout, MDRout,
  input  logic        Inportout, Cout,
  input  logic [31:0] Mdatain,
  output logic [31:0] BusMuxOut
);

  localparam logic [4:0] c_ADD  = 5'b00011;
  localparam logic [4:0] c_SUB  = 5'b00100;
  localparam logic [4:0] c_AND  = 5'b00101;
  localparam logic [4:0] c_OR   = 5'b00110;
  localparam logic [4:0] c_SHR  = 5'b00111;
  localparam logic [4:0] c_SHRA = 5'b01000;
  localparam logic [4:0] c_SHL  = 5'b01001;
  localparam logic [4:0] c_ROR  = 5'b01010;
  localparam logic [4:0] c_ROL  = 5'b01011;
  localparam logic [4:0] c_MUL  = 5'b01111;
  localparam logic [4:0] c_DIV  = 5'b10000;
  localparam logic [4:0] c_NEG  = 5'b10001;
  localparam logic [4:0] c_NOT  = 5'b10010;

  logic [31:0] r_gpr [16];
  logic [31:0] r_pc, r_ir, r_hi, r_lo, r_y, r_mar, r_mdr, r_inport, r_c;
  logic [63:0] r_z;

  logic [15:0] w_rin, w_rout;
  logic [31:0] w_bus;
  logic [63:0] w_alu;
  logic [4:0]  w_sh;
  logic [5:0]  w_sh_inv;
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem, w_ror, w_rol;

  assign w_rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign w_rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  // Sources are applied lowest priority first so the lowest-index strobe wins.
  always_comb begin
    w_bus = '0;
    if (Cout)      w_bus = r_c;
    if (Inportout) w_bus = r_inport;
    if (MDRout)    w_bus = r_mdr;
    if (MARout)    w_bus = r_mar;
    if (IRout)     w_bus = r_ir;
    if (PCout)     w_bus = r_pc;
    if (Zlowout)   w_bus = r_z[31:0];
    if (Zhighout)  w_bus = r_z[63:32];
    if (Yout)      w_bus = r_y;
    if (LOout)     w_bus = r_lo;
    if (HIout)     w_bus = r_hi;
    for (int i = 15; i >= 0; i--) begin
      if (w_rout[i]) w_bus = r_gpr[i];
    end
  end

  assign BusMuxOut = w_bus;

  assign w_sh     = w_bus[4:0];
  assign w_sh_inv = 6'd32 - {1'b0, w_sh};
  assign w_ror    = (r_y >> w_sh) | (r_y << w_sh_inv);
  assign w_rol    = (r_y << w_sh) | (r_y >> w_sh_inv);
  assign w_prod   = $signed(r_y) * $signed(w_bus);
  assign w_quo    = $signed(r_y) / $signed(w_bus);
  assign w_rem    = $signed(r_y) % $signed(w_bus);

  always_comb begin
    w_alu = '0;
    if (IncPC) begin
      w_alu = {32'b0, w_bus + 32'd1};
    end else begin
      case (opcode)
        c_ADD:   w_alu = {32'b0, r_y + w_bus};
        c_SUB:   w_alu = {32'b0, r_y - w_bus};
        c_AND:   w_alu = {32'b0, r_y & w_bus};
        c_OR:    w_alu = {32'b0, r_y | w_bus};
        c_SHR:   w_alu = {32'b0, r_y >> w_sh};
        c_SHRA:  w_alu = {32'b0, $signed(r_y) >>> w_sh};
        c_SHL:   w_alu = {32'b0, r_y << w_sh};
        c_ROR:   w_alu = {32'b0, w_ror};
        c_ROL:   w_alu = {32'b0, w_rol};
        c_MUL:   w_alu = w_prod;
        c_DIV:   w_alu = (w_bus == 32'd0) ? {r_y, 32'hFFFF_FFFF} : {w_rem, w_quo};
        c_NEG:   w_alu = {32'b0, 32'd0 - w_bus};
        c_NOT:   w_alu = {32'b0, ~w_bus};
        default: w_alu = '0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
      r_pc     <= '0;
      r_ir     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_mar    <= '0;
      r_mdr    <= '0;
      r_inport <= '0;
      r_c      <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (w_rin[i]) r_gpr[i] <= w_bus;
      end
      if (HIin)     r_hi       <= w_bus;
      if (LOin)     r_lo       <= w_bus;
      if (Yin)      r_y        <= w_bus;
      if (Zhighin)  r_z[63:32] <= w_alu[63:32];
      if (Zlowin)   r_z[31:0]  <= w_alu[31:0];
      if (PCin)     r_pc       <= w_bus;
      if (IRin)     r_ir       <= w_bus;
      if (MARin)    r_mar      <= w_bus;
      if (MDRin)    r_mdr      <= Read ? Mdatain : w_bus;
      if (Inportin) r_inport   <= w_bus;
      if (Cin)      r_c        <= w_bus;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_datapath.sv
// ==== tb_cpu_datapath : vector table, directed sequences and randomized ALU/GPR checks ====
// ==== rev 1.0 ====
`default_nettype none

module tb_cpu_datapath;

  // Strobe index map: 0-15 R0-R15, 16 HI, 17 LO, 18 Y, 19 Zhigh, 20 Zlow, 21 PC,
  // 22 IR, 23 MAR, 24 MDR, 25 Inport, 26 C.
  localparam int c_HI = 16, c_LO = 17, c_Y = 18, c_ZH = 19, c_ZL = 20, c_PC = 21;
  localparam int c_IR = 22, c_MAR = 23, c_MDR = 24, c_INP = 25, c_C = 26;

  logic        Clock = 1'b0;
  logic        clear, Read, IncPC;
  logic [4:0]  opcode;
  logic [26:0] ins, outs;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clock = ~Clock;

  cpu_datapath dut (
    .Clock(Clock), .clear(clear), .Read(Read), .IncPC(IncPC), .opcode(opcode),
    .R0in(ins[0]), .R1in(ins[1]), .R2in(ins[2]), .R3in(ins[3]), .R4in(ins[4]), .R5in(ins[5]),
    .R6in(ins[6]), .R7in(ins[7]), .R8in(ins[8]), .R9in(ins[9]), .R10in(ins[10]), .R11in(ins[11]),
    .R12in(ins[12]), .R13in(ins[13]), .R14in(ins[14]), .R15in(ins[15]),
    .HIin(ins[16]), .LOin(ins[17]), .Yin(ins[18]), .Zhighin(ins[19]), .Zlowin(ins[20]),
    .PCin(ins[21]), .IRin(ins[22]), .MARin(ins[23]), .MDRin(ins[24]), .Inportin(ins[25]),
    .Cin(ins[26]),
    .R0out(outs[0]), .R1out(outs[1]), .R2out(outs[2]), .R3out(outs[3]), .R4out(outs[4]),
    .R5out(outs[5]), .R6out(outs[6]), .R7out(outs[7]), .R8out(outs[8]), .R9out(outs[9]),
    .R10out(outs[10]), .R11out(outs[11]), .R12out(outs[12]), .R13out(outs[13]),
    .R14out(outs[14]), .R15out(outs[15]),
    .HIout(outs[16]), .LOout(outs[17]), .Yout(outs[18]), .Zhighout(outs[19]), .Zlowout(outs[20]),
    .PCout(outs[21]), .IRout(outs[22]), .MARout(outs[23]), .MDRout(outs[24]),
    .Inportout(outs[25]), .Cout(outs[26]),
    .Mdatain(Mdatain), .BusMuxOut(BusMuxOut)
  );

  typedef struct {
    logic [4:0]  op;
    logic        inc;
    logic [31:0] y;
    logic [31:0] b;
    logic [63:0] z;
  } vec_t;

  vec_t vecs [20];

  // Behavioural ALU: bit-at-a-time shifts and 64-bit integer arithmetic.
  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic inc,
                                          input logic [31:0] y, input logic [31:0] b);
    logic [31:0] t;
    int s;
    longint ly, lb, q, r;
    t  = y;
    s  = int'(b[4:0]);
    ly = longint'($signed(y));
    lb = longint'($signed(b));
    if (inc) return {32'b0, b + 32'd1};
    case (op)
      5'd3:  return {32'b0, y + b};
      5'd4:  return {32'b0, y - b};
      5'd5:  return {32'b0, y & b};
      5'd6:  return {32'b0, y | b};
      5'd7:  begin repeat (s) t = {1'b0, t[31:1]};  return {32'b0, t}; end
      5'd8:  begin repeat (s) t = {t[31], t[31:1]}; return {32'b0, t}; end
      5'd9:  begin repeat (s) t = {t[30:0], 1'b0};  return {32'b0, t}; end
      5'd10: begin repeat (s) t = {t[0], t[31:1]};  return {32'b0, t}; end
      5'd11: begin repeat (s) t = {t[30:0], t[31]}; return {32'b0, t}; end
      5'd15: return 64'(ly * lb);
      5'd16: begin
        if (b == 32'd0) return {y, 32'hFFFF_FFFF};
        q = ly / lb;
        r = ly - q * lb;
        return {r[31:0], q[31:0]};
      end
      5'd17: return {32'b0, 32'd0 - b};
      5'd18: return {32'b0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
    ins = '0; outs = '0; Read = 1'b0; IncPC = 1'b0; opcode = 5'd0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; ins[c_MDR] = 1'b1;
    tick;
  endtask

  task automatic write_reg(input int idx, input logic [31:0] v);
    load_mdr(v);
    outs[c_MDR] = 1'b1; ins[idx] = 1'b1;
    tick;
  endtask

  task automatic read_reg(input int idx, output logic [31:0] v);
    outs = '0; outs[idx] = 1'b1;
    #1 v = BusMuxOut;
    outs = '0;
  endtask

  task automatic do_alu(input logic [4:0] op, input logic inc, input logic [31:0] y,
                        input logic [31:0] b, output logic [63:0] z);
    write_reg(c_Y, y);
    load_mdr(b);
    outs[c_MDR] = 1'b1; opcode = op; IncPC = inc; ins[c_ZH] = 1'b1; ins[c_ZL] = 1'b1;
    tick;
    read_reg(c_ZH, z[63:32]);
    read_reg(c_ZL, z[31:0]);
  endtask

  logic [31:0] v;
  logic [63:0] z;
  logic [31:0] gpr_model [16];
  logic [4:0]  ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                            5'd15, 5'd16, 5'd17, 5'd18};

  initial begin
    vecs[0]  = '{5'b00011, 1'b0, 32'd8,          32'd9,          64'h0000_0000_0000_0011};
    vecs[1]  = '{5'b00100, 1'b0, 32'd5,          32'd7,          64'h0000_0000_FFFF_FFFE};
    vecs[2]  = '{5'b00101, 1'b0, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  64'h0000_0000_00F0_00F0};
    vecs[3]  = '{5'b00110, 1'b0, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  64'h0000_0000_FFF0_FFF0};
    vecs[4]  = '{5'b00111, 1'b0, 32'h8000_0001,  32'd1,          64'h0000_0000_4000_0000};
    vecs[5]  = '{5'b01000, 1'b0, 32'h8000_0001,  32'd1,          64'h0000_0000_C000_0000};
    vecs[6]  = '{5'b01001, 1'b0, 32'h8000_0001,  32'd1,          64'h0000_0000_0000_0002};
    vecs[7]  = '{5'b01010, 1'b0, 32'h8000_0001,  32'd1,          64'h0000_0000_C000_0000};
    vecs[8]  = '{5'b01011, 1'b0, 32'h8000_0001,  32'd1,          64'h0000_0000_0000_0003};
    vecs[9]  = '{5'b01010, 1'b0, 32'h1234_5678,  32'h20,         64'h0000_0000_1234_5678};
    vecs[10] = '{5'b01111, 1'b0, 32'hFFFF_FFFA,  32'd4,          64'hFFFF_FFFF_FFFF_FFE8};
    vecs[11] = '{5'b10000, 1'b0, 32'hFFFF_FFFA,  32'd4,          64'hFFFF_FFFE_FFFF_FFFF};
    vecs[12] = '{5'b10000, 1'b0, 32'd7,          32'd0,          64'h0000_0007_FFFF_FFFF};
    vecs[13] = '{5'b10000, 1'b0, 32'd7,          32'hFFFF_FFFE,  64'h0000_0001_FFFF_FFFD};
    vecs[14] = '{5'b10001, 1'b0, 32'd9,          32'd1,          64'h0000_0000_FFFF_FFFF};
    vecs[15] = '{5'b10010, 1'b0, 32'd9,          32'h0F0F_0F0F,  64'h0000_0000_F0F0_F0F0};
    vecs[16] = '{5'b01100, 1'b0, 32'd1,          32'd2,          64'h0000_0000_0000_0000};
    vecs[17] = '{5'b01111, 1'b0, 32'h8000_0000,  32'd2,          64'hFFFF_FFFF_0000_0000};
    vecs[18] = '{5'b00011, 1'b1, 32'd5,          32'd7,          64'h0000_0000_0000_0008};
    vecs[19] = '{5'b00000, 1'b1, 32'd5,          32'hFFFF_FFFF,  64'h0000_0000_0000_0000};

    clear = 1'b0; Read = 1'b0; IncPC = 1'b0; opcode = '0; ins = '0; outs = '0; Mdatain = '0;
    tick;
    clear = 1'b1;

    // Make every register non-zero, then reset with every strobe active.
    load_mdr(32'hA5A5_0001);
    outs[c_MDR] = 1'b1; ins = '1; IncPC = 1'b1;
    tick;
    outs[c_MDR] = 1'b1; opcode = 5'b01111; ins[c_ZH] = 1'b1;
    tick;
    read_reg(c_ZH, v);
    check("pre-reset Zhigh nonzero", 64'(v != 32'd0), 64'd1);
    clear = 1'b0; ins = '1; outs = '1; Read = 1'b1; IncPC = 1'b1; Mdatain = '1; opcode = 5'd3;
    tick;
    clear = 1'b1;
    for (int i = 0; i < 27; i++) begin
      read_reg(i, v);
      check($sformatf("reset src %0d", i), 64'(v), 64'd0);
    end
    #1 check("idle bus", 64'(BusMuxOut), 64'd0);

    // Register-transfer add sequence.
    write_reg(2, 32'd8);
    write_reg(3, 32'd9);
    outs[2] = 1'b1; ins[c_Y] = 1'b1; tick;
    outs[3] = 1'b1; opcode = 5'b00011; ins[c_ZL] = 1'b1; ins[c_ZH] = 1'b1; tick;
    outs[c_ZL] = 1'b1; ins[1] = 1'b1; tick;
    read_reg(1, v); check("R1 add", 64'(v), 64'h11);

    // Fetch-style PC increment and IR load.
    write_reg(c_PC, 32'd5);
    outs[c_PC] = 1'b1; IncPC = 1'b1; ins[c_ZL] = 1'b1; ins[c_MAR] = 1'b1; tick;
    read_reg(c_MAR, v); check("MAR=PC", 64'(v), 64'd5);
    outs[c_ZL] = 1'b1; ins[c_PC] = 1'b1; tick;
    read_reg(c_PC, v); check("PC inc", 64'(v), 64'd6);
    write_reg(c_IR, 32'h1891_8000);
    read_reg(c_IR, v); check("IR load", 64'(v), 64'h1891_8000);

    // MDR from bus when Read is low.
    outs[2] = 1'b1; ins[c_MDR] = 1'b1; Mdatain = 32'hDEAD_BEEF; tick;
    read_reg(c_MDR, v); check("MDR from bus", 64'(v), 64'd8);

    // Bus priority with multiple drivers.
    write_reg(5, 32'h55); write_reg(9, 32'h99);
    write_reg(c_HI, 32'h1111); write_reg(15, 32'hF15); write_reg(c_C, 32'hCCCC);
    outs[5] = 1'b1; outs[9] = 1'b1; #1 check("prio R5>R9", 64'(BusMuxOut), 64'h55); outs = '0;
    outs[15] = 1'b1; outs[c_HI] = 1'b1; #1 check("prio R15>HI", 64'(BusMuxOut), 64'hF15); outs = '0;
    outs[c_HI] = 1'b1; outs[c_C] = 1'b1; #1 check("prio HI>C", 64'(BusMuxOut), 64'h1111); outs = '0;

    // Same-cycle read and write captures the pre-edge value through Z.
    outs[5] = 1'b1; ins[5] = 1'b1; IncPC = 1'b1; ins[c_ZL] = 1'b1; tick;
    read_reg(5, v); check("R5 self load", 64'(v), 64'h55);
    read_reg(c_ZL, v); check("Zlow inc R5", 64'(v), 64'h56);

    for (int i = 0; i < 20; i++) begin
      do_alu(vecs[i].op, vecs[i].inc, vecs[i].y, vecs[i].b, z);
      check($sformatf("vec %0d op %b", i, vecs[i].op), z, vecs[i].z);
    end

    // Randomized ALU operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [4:0]  op;
      logic [31:0] ry, rb;
      logic        rinc;
      op   = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 12)];
      ry   = $urandom;
      rb   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rinc = ($urandom_range(0, 7) == 0);
      if (op == 5'd16 && ry == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      do_alu(op, rinc, ry, rb, z);
      check($sformatf("rand alu op %b y %h b %h inc %b", op, ry, rb, rinc),
            z, ref_alu(op, rinc, ry, rb));
    end

    // Randomized GPR writes against a register-file scoreboard.
    for (int i = 0; i < 16; i++) begin
      gpr_model[i] = $urandom;
      write_reg(i, gpr_model[i]);
    end
    for (int i = 0; i < 20; i++) begin
      int r;
      r = $urandom_range(0, 15);
      gpr_model[r] = $urandom;
      write_reg(r, gpr_model[r]);
    end
    for (int i = 0; i < 16; i++) begin
      read_reg(i, v);
      check($sformatf("gpr R%0d", i), 64'(v), 64'(gpr_model[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
